// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary definitions: EX/MEM payload layout, control bit indices
// and occupancy encodings used by the stage buffers.
package pipe_pkg;

    localparam int ZERO_W = 1;
    localparam int B_W    = 32;
    localparam int NPC_W  = 32;
    localparam int ALU_W  = 32;
    localparam int RD_W   = 5;

    localparam int RD_LSB   = 0;
    localparam int ALU_LSB  = RD_LSB + RD_W;
    localparam int NPC_LSB  = ALU_LSB + ALU_W;
    localparam int B_LSB    = NPC_LSB + NPC_W;
    localparam int ZERO_LSB = B_LSB + B_W;
    localparam int EXMEM_W  = ZERO_LSB + ZERO_W;

    localparam int EXMEM_CTRL_W = 5;
    localparam int CTRL_BRANCH  = 0;
    localparam int CTRL_MEM_RD  = 1;
    localparam int CTRL_MEM_WR  = 2;
    localparam int CTRL_REG_WR  = 3;
    localparam int CTRL_MEM2REG = 4;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    // The skid entry is only ever valid behind a valid main entry.
    function automatic logic [1:0] occ_of(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One buffer entry: valid flag plus payload and control, with clear taking
// priority over load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_W,
    parameter int CTRL_W = EXMEM_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Clear only drops the valid flag; payload keeps stale contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, flush, optional skid entry
// and a saturating stall-cycle counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_W,
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              w_push, w_pop;
    logic              w_main_valid, w_skid_valid;
    logic              w_main_load, w_main_clr;
    logic [DATA_W-1:0] w_main_data, w_main_din;
    logic [CTRL_W-1:0] w_main_ctrl, w_main_cin;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_push = in_valid & in_ready;
    assign w_pop  = w_main_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              w_skid_load, w_skid_clr;
            logic [DATA_W-1:0] w_skid_data;
            logic [CTRL_W-1:0] w_skid_ctrl;

            // Ready comes straight off the skid valid flop, never from out_ready.
            assign in_ready    = !w_skid_valid;
            assign w_main_load = w_skid_valid ? w_pop : (w_push & (!w_main_valid | w_pop));
            assign w_main_clr  = flush | (w_pop & !w_push & !w_skid_valid);
            assign w_skid_load = w_push & w_main_valid & !w_pop;
            assign w_skid_clr  = flush | (w_skid_valid & w_pop);
            assign w_main_din  = w_skid_valid ? w_skid_data : in_data;
            assign w_main_cin  = w_skid_valid ? w_skid_ctrl : in_ctrl;

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk     (clk),
                .reset   (reset),
                .i_clr   (w_skid_clr),
                .i_load  (w_skid_load),
                .i_data  (in_data),
                .i_ctrl  (in_ctrl),
                .o_valid (w_skid_valid),
                .o_data  (w_skid_data),
                .o_ctrl  (w_skid_ctrl)
            );
        end else begin : g_noskid
            assign w_skid_valid = 1'b0;
            assign in_ready     = !w_main_valid | out_ready;
            assign w_main_load  = w_push;
            assign w_main_clr   = flush | (w_pop & !w_push);
            assign w_main_din   = in_data;
            assign w_main_cin   = in_ctrl;
        end
    endgenerate

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_main_clr),
        .i_load  (w_main_load),
        .i_data  (w_main_din),
        .i_ctrl  (w_main_cin),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

    // Flush does not touch the counter; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= '0;
        else if (w_main_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
    assign occupancy = occ_of(w_main_valid, w_skid_valid);
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: a skid build and a single-entry build share one stimulus bus;
// each check looks at the build the vector is aimed at.
module tb_pipe_stage_buf;

    localparam int DW = 102;
    localparam int CW = 5;

    logic          clk, reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          s_in_ready, s_out_valid, n_in_ready, n_out_valid;
    logic [DW-1:0] s_out_data, n_out_data;
    logic [CW-1:0] s_out_ctrl, n_out_ctrl;
    logic [1:0]    s_occ, n_occ;
    logic [3:0]    s_st, n_st;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_dut_s (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_ctrl(s_out_ctrl), .occupancy(s_occ), .stall_cnt(s_st)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(4)) u_dut_n (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_data(n_out_data), .out_ctrl(n_out_ctrl), .occupancy(n_occ), .stall_cnt(n_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         pre_rst;
        bit         skid;
        bit         fl;
        bit         iv;
        logic [7:0] id;
        logic [4:0] ic;
        bit         ordy;
        bit         ev;
        logic [7:0] ed;
        logic [4:0] ec;
        logic [1:0] eo;
        bit         eir;
        logic [3:0] es;
        bit         ces;
    } vec_t;

    vec_t tbl[$];

    // Tag appears at both ends of the payload so the full width is exercised.
    function automatic logic [DW-1:0] mk_data(input logic [7:0] tag);
        return {tag, 86'd0, tag};
    endfunction

    function automatic vec_t mk(bit r, bit sk, bit fl, bit iv, logic [7:0] id, logic [4:0] ic,
                                bit ordy, bit ev, logic [7:0] ed, logic [4:0] ec,
                                logic [1:0] eo, bit eir, logic [3:0] es, bit ces);
        vec_t v;
        v.pre_rst = r;  v.skid = sk; v.fl = fl;  v.iv = iv; v.id = id; v.ic = ic;
        v.ordy = ordy;  v.ev = ev;   v.ed = ed;  v.ec = ec; v.eo = eo; v.eir = eir;
        v.es = es;      v.ces = ces;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    localparam logic [7:0] A = 8'hA1, B = 8'hB2, C = 8'hC3, D = 8'hD4, E = 8'hE5;
    localparam logic [4:0] CA = 5'b00011, CB = 5'b01000, CC = 5'b10001;
    localparam logic [4:0] CD = 5'b11111, CE = 5'b00110, CS = 5'b00101;

    initial begin
        logic          a_v, a_ir;
        logic [DW-1:0] a_d;
        logic [CW-1:0] a_c;
        logic [1:0]    a_o;
        logic [3:0]    a_s;
        bit            ok;

        // Reset held with in_valid high must not capture anything.
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = mk_data(8'h99); in_ctrl = 5'b11111;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_state", {s_out_valid, s_out_ctrl, s_occ, s_st, s_in_ready}, {1'b0, 5'd0, 2'd0, 4'd0, 1'b1});
        check("rst_n_state", {n_out_valid, n_out_ctrl, n_occ, n_st, n_in_ready}, {1'b0, 5'd0, 2'd0, 4'd0, 1'b1});
        @(negedge clk);
        reset = 1'b1; in_data = mk_data(8'h11); in_ctrl = 5'b10000;
        #1;
        check("rst_release_empty", s_out_valid, 1'b0);
        @(posedge clk); #1;
        check("rst_first_push_s", {s_out_valid, s_out_data, s_out_ctrl}, {1'b1, mk_data(8'h11), 5'b10000});
        check("rst_first_push_n", {n_out_valid, n_out_data, n_out_ctrl}, {1'b1, mk_data(8'h11), 5'b10000});
        @(negedge clk);
        in_valid = 1'b0;

        // Streaming, both builds: 1-cycle latency, no bubbles.
        for (int sk = 1; sk >= 0; sk--) begin
            for (int i = 1; i <= 8; i++)
                tbl.push_back(mk(i == 1, sk[0], 0, 1, 8'(i), CS, 1, 1, 8'(i), CS, 2'd1, 1, 4'd0, 1));
            tbl.push_back(mk(0, sk[0], 0, 0, 8'd0, 5'd0, 1, 0, 8'd0, 5'd0, 2'd0, 1, 4'd0, 1));
        end
        // Skid backpressure: A,B held, C refused until the skid drains.
        tbl.push_back(mk(1, 1, 0, 1, A, CA, 0, 1, A, CA, 2'd1, 1, 4'd0, 1));
        tbl.push_back(mk(0, 1, 0, 1, B, CB, 0, 1, A, CA, 2'd2, 0, 4'd1, 1));
        tbl.push_back(mk(0, 1, 0, 1, C, CC, 0, 1, A, CA, 2'd2, 0, 4'd2, 1));
        tbl.push_back(mk(0, 1, 0, 1, C, CC, 1, 1, B, CB, 2'd1, 1, 4'd2, 1));
        tbl.push_back(mk(0, 1, 0, 1, C, CC, 1, 1, C, CC, 2'd1, 1, 4'd2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 8'd0, 5'd0, 1, 0, 8'd0, 5'd0, 2'd0, 1, 4'd2, 1));
        // Single-entry backpressure: ready tracks out_ready while full.
        tbl.push_back(mk(1, 0, 0, 1, A, CA, 0, 1, A, CA, 2'd1, 0, 4'd0, 1));
        tbl.push_back(mk(0, 0, 0, 1, B, CB, 0, 1, A, CA, 2'd1, 0, 4'd1, 1));
        tbl.push_back(mk(0, 0, 0, 1, B, CB, 1, 1, B, CB, 2'd1, 1, 4'd1, 1));
        tbl.push_back(mk(0, 0, 0, 1, C, CC, 1, 1, C, CC, 2'd1, 1, 4'd1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'd0, 5'd0, 1, 0, 8'd0, 5'd0, 2'd0, 1, 4'd1, 1));
        // Skid flush at occupancy 2 with D offered and a stall in the same cycle.
        tbl.push_back(mk(1, 1, 0, 1, A, CA, 0, 1, A, CA, 2'd1, 1, 4'd0, 1));
        tbl.push_back(mk(0, 1, 0, 1, B, CB, 0, 1, A, CA, 2'd2, 0, 4'd1, 1));
        tbl.push_back(mk(0, 1, 1, 1, D, CD, 0, 0, 8'd0, 5'd0, 2'd0, 1, 4'd0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'd0, 5'd0, 1, 0, 8'd0, 5'd0, 2'd0, 1, 4'd0, 0));
        tbl.push_back(mk(0, 1, 0, 1, E, CE, 1, 1, E, CE, 2'd1, 1, 4'd0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'd0, 5'd0, 1, 0, 8'd0, 5'd0, 2'd0, 1, 4'd0, 0));
        // Single-entry flush discards both the held beat and the incoming one.
        tbl.push_back(mk(1, 0, 0, 1, A, CA, 0, 1, A, CA, 2'd1, 0, 4'd0, 1));
        tbl.push_back(mk(0, 0, 1, 1, D, CD, 0, 0, 8'd0, 5'd0, 2'd0, 1, 4'd0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'd0, 5'd0, 1, 0, 8'd0, 5'd0, 2'd0, 1, 4'd0, 0));

        foreach (tbl[i]) begin
            if (tbl[i].pre_rst) do_reset();
            @(negedge clk);
            flush = tbl[i].fl; in_valid = tbl[i].iv; in_data = mk_data(tbl[i].id);
            in_ctrl = tbl[i].ic; out_ready = tbl[i].ordy;
            @(posedge clk); #1;
            if (tbl[i].skid) begin
                a_v = s_out_valid; a_d = s_out_data; a_c = s_out_ctrl; a_o = s_occ; a_ir = s_in_ready; a_s = s_st;
            end else begin
                a_v = n_out_valid; a_d = n_out_data; a_c = n_out_ctrl; a_o = n_occ; a_ir = n_in_ready; a_s = n_st;
            end
            ok = (a_v === tbl[i].ev) && (a_c === tbl[i].ec) && (a_o === tbl[i].eo) && (a_ir === tbl[i].eir);
            if (tbl[i].ev && (a_d !== mk_data(tbl[i].ed))) ok = 0;
            if (tbl[i].ces && (a_s !== tbl[i].es)) ok = 0;
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL vec%0d skid=%0b: got v=%0b d=%h c=%b occ=%0d ir=%0b st=%0d, want v=%0b d=%h c=%b occ=%0d ir=%0b st=%0d",
                         i, tbl[i].skid, a_v, a_d[7:0], a_c, a_o, a_ir, a_s,
                         tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].eo, tbl[i].eir, tbl[i].es);
            end
        end

        // Stall counter saturation on the skid build (4-bit counter).
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = mk_data(8'h55); in_ctrl = 5'b00100; out_ready = 1'b0;
        @(posedge clk); #1;
        check("sat_start", {s_out_valid, s_st}, {1'b1, 4'd0});
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            check($sformatf("sat_k%0d", k), {s_st, s_out_valid, s_out_data, s_out_ctrl},
                  {((k > 15) ? 4'd15 : 4'(k)), 1'b1, mk_data(8'h55), 5'b00100});
        end

        // Single-entry ready is a combinational function of out_ready when full.
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = mk_data(A); in_ctrl = CA; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1; check("comb_rdy_lo", n_in_ready, 1'b0);
        out_ready = 1'b1;
        #1; check("comb_rdy_hi", n_in_ready, 1'b1);
        out_ready = 1'b0;
        #1; check("comb_rdy_lo2", n_in_ready, 1'b0);

        // Async reset mid-stream with the skid build full.
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = mk_data(A); in_ctrl = CA; out_ready = 1'b0;
        @(negedge clk);
        in_data = mk_data(B); in_ctrl = CB;
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_full", s_occ, 2'd2);
        #2 reset = 1'b0;
        #1;
        check("midrst_async", {s_out_valid, s_occ, s_st, s_in_ready, n_out_valid}, {1'b1 ^ 1'b1, 2'd0, 4'd0, 1'b1, 1'b0});
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_quiet%0d", k), {s_out_valid, n_out_valid, s_occ}, {1'b0, 1'b0, 2'd0});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
